imem_arbiter: RTL and testbench
===============================

IMEM_ARBITER -- requirements
Module: imem_arbiter

Interface
REQ-001 Parameter AW, default 8, instruction-memory address width (matches `MEM_SPACE).
REQ-002 Parameter DW, default 16, instruction word width (matches `ISIZE).
REQ-003 Parameter STARVE_MAX, default 4, consecutive write grants tolerated while a fetch waits (range 1..15).
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset, synchronous, active-low.
REQ-006 f_req  input  1  fetch read request; held with f_addr stable until f_gnt.
REQ-007 f_addr  input  AW  fetch address.
REQ-008 f_flush  input  1  redirect; cancels an in-flight fetch.
REQ-009 f_gnt  output  1  one-cycle pulse, fetch accepted and issued to memory.
REQ-010 f_valid  output  1  one-cycle pulse, f_data holds the fetched word.
REQ-011 f_data  output  DW  fetched instruction word.
REQ-012 w_req  input  1  loader write request; held with w_addr/w_data stable until w_gnt.
REQ-013 w_addr  input  AW  write address.
REQ-014 w_data  input  DW  instruction word to store.
REQ-015 w_gnt  output  1  one-cycle pulse, write committed to memory.
REQ-016 mem_en, mem_we  output  1 each  memory access enable and write enable.
REQ-017 mem_addr  output  AW; mem_wdata  output  DW  memory address and write data.
REQ-018 mem_rdata  input  DW  memory read data, valid the cycle after an enabled read.
REQ-019 busy  output  1  high in any state other than IDLE.

Function
REQ-020 FSM states IDLE, RD_ISSUE, RD_DATA, WR; all outputs derived from registered state and latched address/data.
REQ-021 IDLE: if w_req and write wins arbitration, latch w_addr/w_data, go WR; else if f_req, latch f_addr, go RD_ISSUE; else stay.
REQ-022 Default priority: write over fetch when both requested in the same IDLE cycle.
REQ-023 WR: mem_en=1, mem_we=1, mem_addr/mem_wdata = latched values, w_gnt=1; next state IDLE.
REQ-024 RD_ISSUE: mem_en=1, mem_we=0, mem_addr = latched address, f_gnt=1; next state RD_DATA.
REQ-025 RD_DATA: f_valid=1 and f_data=mem_rdata unless cancelled; next state IDLE.
REQ-026 Latency: request sampled in IDLE at cycle T -> gnt at T+1 -> f_valid at T+2; one access per 2 (write) or 3 (read) cycles.
REQ-027 f_flush high in RD_ISSUE or RD_DATA sets a cancel flag; f_valid stays 0 for that fetch; flag clears on return to IDLE.
REQ-028 f_flush in IDLE or WR has no effect; a flushed read still completes its memory cycle (no abort of mem_en).
REQ-029 f_data holds its last value outside RD_DATA; mem_wdata = 0 whenever mem_we=0.
REQ-030 Withdrawn requests (req dropped while in IDLE before latching) are never granted.

Reset
REQ-031 rst low at a rising edge: state IDLE, starvation counter 0, cancel flag 0, f_data 0.
REQ-032 While rst is low: f_gnt, f_valid, w_gnt, mem_en, mem_we, busy all 0 (combinationally forced), so a WR/RD_ISSUE cycle coinciding with reset issues nothing.
REQ-033 Reset mid-operation discards the pending access; requester re-requests after reset releases.

Configuration
REQ-034 Macro IMEM_STARVE_GUARD_EN defined: a 4-bit counter increments on each write grant while f_req is high, clears on any fetch grant or when f_req is low; when counter equals STARVE_MAX, IDLE grants fetch over write.
REQ-035 Macro undefined: no counter; write always wins, fetch may starve indefinitely.

Verification
REQ-036 f_req=1, f_addr=0x05, mem returns 0x7000 -> f_gnt at T+1 with mem_addr=0x05, f_valid=1, f_data=0x7000 at T+2.
REQ-037 w_req=1, w_addr=0x10, w_data=0x1234 -> T+1 mem_en=mem_we=1, mem_addr=0x10, mem_wdata=0x1234, w_gnt=1.
REQ-038 w_req and f_req held high continuously, guard enabled, STARVE_MAX=4 -> 4 write grants, then 1 fetch grant, repeating; guard disabled -> writes only.
REQ-039 Fetch granted, f_flush=1 in RD_ISSUE -> f_valid stays 0 at T+2; next fetch to 0x06 returns valid normally.
REQ-040 rst driven low during WR cycle -> mem_we=0 that cycle, state IDLE after edge, all outputs 0; w_req reissued -> w_gnt 2 cycles after release.

Source files
------------

// File: rtl/imem_arbiter.sv
// rtl/imem_arbiter.sv - instruction-memory arbiter between fetch reads and loader writes
//
// Single-port instruction memory shared by the fetch unit (reads) and the
// program loader (writes). A write costs 2 cycles (IDLE, WR) and a read
// costs 3 cycles (IDLE, RD_ISSUE, RD_DATA). Writes win ties by default.
//
// Optional feature: define IMEM_STARVE_GUARD_EN to add a starvation guard.
// After STARVE_MAX consecutive write grants with a fetch waiting, the next
// IDLE decision goes to the fetch.
//
// Ports:
//   clk        clock, rising-edge
//   rst        synchronous active-low reset
//   f_req      fetch request (held with f_addr until f_gnt)
//   f_addr     fetch address
//   f_flush    redirect, cancels the in-flight fetch result
//   f_gnt      pulse: fetch issued to memory
//   f_valid    pulse: f_data holds the fetched word
//   f_data     fetched word, holds its last value between fetches
//   w_req      write request (held with w_addr/w_data until w_gnt)
//   w_addr     write address
//   w_data     write data
//   w_gnt      pulse: write committed to memory
//   mem_en     memory enable
//   mem_we     memory write enable
//   mem_addr   memory address
//   mem_wdata  memory write data (0 when not writing)
//   mem_rdata  memory read data, valid the cycle after an enabled read
//   busy       high whenever the FSM is not in IDLE

module imem_arbiter #(
  parameter int AW         = 8,
  parameter int DW         = 16,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          f_req,
  input  logic [AW-1:0] f_addr,
  input  logic          f_flush,
  output logic          f_gnt,
  output logic          f_valid,
  output logic [DW-1:0] f_data,
  input  logic          w_req,
  input  logic [AW-1:0] w_addr,
  input  logic [DW-1:0] w_data,
  output logic          w_gnt,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_ISSUE = 2'd1,
    RD_DATA  = 2'd2,
    WR       = 2'd3
  } state_t;

  state_t        state_q;
  logic          cancel_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [DW-1:0] f_data_q;
  logic          fetch_first;
  logic          rd_data_live;

`ifdef IMEM_STARVE_GUARD_EN
  logic [3:0] starve_cnt_q;
  logic [3:0] starve_cnt_d;

  // Counts write grants taken while a fetch is waiting. A fetch grant or a
  // dropped fetch request restarts the count.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!f_req || state_q == RD_ISSUE) begin
      starve_cnt_d = 4'd0;
    end else if (state_q == WR) begin
      starve_cnt_d = starve_cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      starve_cnt_q <= 4'd0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end

  assign fetch_first = f_req && (starve_cnt_q == 4'(STARVE_MAX));
`else
  assign fetch_first = 1'b0;
`endif

  // Arbitration FSM. Addresses and data are latched on the IDLE decision so
  // that the memory-facing outputs depend only on registered values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      cancel_q <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      f_data_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          cancel_q <= 1'b0;
          if (w_req && !fetch_first) begin
            addr_q  <= w_addr;
            wdata_q <= w_data;
            state_q <= WR;
          end else if (f_req) begin
            addr_q  <= f_addr;
            state_q <= RD_ISSUE;
          end
        end
        WR: begin
          state_q <= IDLE;
        end
        RD_ISSUE: begin
          if (f_flush) begin
            cancel_q <= 1'b1;
          end
          state_q <= RD_DATA;
        end
        RD_DATA: begin
          if (!cancel_q && !f_flush) begin
            f_data_q <= mem_rdata;
          end
          cancel_q <= 1'b0;
          state_q  <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // A flush arriving in RD_DATA itself must still suppress the result, so the
  // live flush input joins the registered cancel flag here.
  assign rd_data_live = rst && (state_q == RD_DATA) && !cancel_q && !f_flush;

  // Every strobe is gated by rst so an access coinciding with reset issues nothing.
  assign f_gnt     = rst && (state_q == RD_ISSUE);
  assign w_gnt     = rst && (state_q == WR);
  assign mem_en    = rst && ((state_q == RD_ISSUE) || (state_q == WR));
  assign mem_we    = rst && (state_q == WR);
  assign busy      = rst && (state_q != IDLE);
  assign f_valid   = rd_data_live;
  assign f_data    = rd_data_live ? mem_rdata : f_data_q;
  assign mem_addr  = mem_en ? addr_q : '0;
  assign mem_wdata = mem_we ? wdata_q : '0;

endmodule

// File: tb/tb_imem_arbiter.sv
// tb/tb_imem_arbiter.sv - directed vector bench for imem_arbiter

module tb_imem_arbiter;

  localparam int AW = 8;
  localparam int DW = 16;
  localparam int SMAX = 4;

  logic          clk;
  logic          rst;
  logic          f_req;
  logic [AW-1:0] f_addr;
  logic          f_flush;
  logic          f_gnt;
  logic          f_valid;
  logic [DW-1:0] f_data;
  logic          w_req;
  logic [AW-1:0] w_addr;
  logic [DW-1:0] w_data;
  logic          w_gnt;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          busy;

  int n_vec;
  int n_fail;

  imem_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(SMAX)) dut (
    .clk       (clk),
    .rst       (rst),
    .f_req     (f_req),
    .f_addr    (f_addr),
    .f_flush   (f_flush),
    .f_gnt     (f_gnt),
    .f_valid   (f_valid),
    .f_data    (f_data),
    .w_req     (w_req),
    .w_addr    (w_addr),
    .w_data    (w_data),
    .w_gnt     (w_gnt),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          rst;
    logic          f_req;
    logic [AW-1:0] f_addr;
    logic          f_flush;
    logic          w_req;
    logic [AW-1:0] w_addr;
    logic [DW-1:0] w_data;
    logic [DW-1:0] rdata;
    logic          e_fgnt;
    logic          e_fvld;
    logic [DW-1:0] e_fdata;
    logic          e_wgnt;
    logic          e_en;
    logic          e_we;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata;
    logic          e_busy;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %0h, expected %0h", name, idx, act, exp);
    end
  endtask

  int wr_cnt;
  int rd_cnt;
  int since;

  initial begin
    n_vec = 0;
    n_fail = 0;
    rst = 1'b0; f_req = 1'b0; f_addr = '0; f_flush = 1'b0;
    w_req = 1'b0; w_addr = '0; w_data = '0; mem_rdata = '0;

    //              rst fr fadr   fl wr wadr   wdata     rdata     | fgnt fv fdata     wg en we madr   mwdata    busy
    vecs.push_back(vec_t'{0, 0, 8'h00, 0, 0, 8'h00, 16'h0000, 16'h0000, 0, 0, 16'h0000, 0, 0, 0, 8'h00, 16'h0000, 0});
    vecs.push_back(vec_t'{1, 1, 8'h05, 0, 0, 8'h00, 16'h0000, 16'h0000, 0, 0, 16'h0000, 0, 0, 0, 8'h00, 16'h0000, 0});
    vecs.push_back(vec_t'{1, 1, 8'h05, 0, 0, 8'h00, 16'h0000, 16'h0000, 1, 0, 16'h0000, 0, 1, 0, 8'h05, 16'h0000, 1});
    vecs.push_back(vec_t'{1, 0, 8'h00, 0, 0, 8'h00, 16'h0000, 16'h7000, 0, 1, 16'h7000, 0, 0, 0, 8'h00, 16'h0000, 1});
    vecs.push_back(vec_t'{1, 0, 8'h00, 0, 1, 8'h10, 16'h1234, 16'hBEEF, 0, 0, 16'h7000, 0, 0, 0, 8'h00, 16'h0000, 0});
    vecs.push_back(vec_t'{1, 0, 8'h00, 0, 1, 8'h10, 16'h1234, 16'h0000, 0, 0, 16'h7000, 1, 1, 1, 8'h10, 16'h1234, 1});
    vecs.push_back(vec_t'{1, 1, 8'h06, 0, 1, 8'h20, 16'hAAAA, 16'h0000, 0, 0, 16'h7000, 0, 0, 0, 8'h00, 16'h0000, 0});
    vecs.push_back(vec_t'{1, 1, 8'h06, 0, 1, 8'h20, 16'hAAAA, 16'h0000, 0, 0, 16'h7000, 1, 1, 1, 8'h20, 16'hAAAA, 1});
    vecs.push_back(vec_t'{1, 1, 8'h06, 0, 0, 8'h00, 16'h0000, 16'h0000, 0, 0, 16'h7000, 0, 0, 0, 8'h00, 16'h0000, 0});
    vecs.push_back(vec_t'{1, 1, 8'h06, 1, 0, 8'h00, 16'h0000, 16'h0000, 1, 0, 16'h7000, 0, 1, 0, 8'h06, 16'h0000, 1});
    vecs.push_back(vec_t'{1, 0, 8'h00, 0, 0, 8'h00, 16'h0000, 16'h1111, 0, 0, 16'h7000, 0, 0, 0, 8'h00, 16'h0000, 1});
    vecs.push_back(vec_t'{1, 1, 8'h06, 0, 0, 8'h00, 16'h0000, 16'h0000, 0, 0, 16'h7000, 0, 0, 0, 8'h00, 16'h0000, 0});
    vecs.push_back(vec_t'{1, 1, 8'h06, 0, 0, 8'h00, 16'h0000, 16'h0000, 1, 0, 16'h7000, 0, 1, 0, 8'h06, 16'h0000, 1});
    vecs.push_back(vec_t'{1, 0, 8'h00, 0, 0, 8'h00, 16'h0000, 16'h2222, 0, 1, 16'h2222, 0, 0, 0, 8'h00, 16'h0000, 1});
    vecs.push_back(vec_t'{1, 0, 8'h00, 1, 1, 8'h30, 16'h5555, 16'h0000, 0, 0, 16'h2222, 0, 0, 0, 8'h00, 16'h0000, 0});
    vecs.push_back(vec_t'{0, 0, 8'h00, 0, 1, 8'h30, 16'h5555, 16'h0000, 0, 0, 16'h2222, 0, 0, 0, 8'h00, 16'h0000, 0});
    vecs.push_back(vec_t'{1, 0, 8'h00, 0, 1, 8'h30, 16'h5555, 16'h0000, 0, 0, 16'h0000, 0, 0, 0, 8'h00, 16'h0000, 0});
    vecs.push_back(vec_t'{1, 0, 8'h00, 0, 1, 8'h30, 16'h5555, 16'h0000, 0, 0, 16'h0000, 1, 1, 1, 8'h30, 16'h5555, 1});
    vecs.push_back(vec_t'{1, 0, 8'h00, 0, 0, 8'h00, 16'h0000, 16'h0000, 0, 0, 16'h0000, 0, 0, 0, 8'h00, 16'h0000, 0});
    vecs.push_back(vec_t'{1, 1, 8'h07, 0, 0, 8'h00, 16'h0000, 16'h0000, 0, 0, 16'h0000, 0, 0, 0, 8'h00, 16'h0000, 0});
    vecs.push_back(vec_t'{1, 1, 8'h07, 0, 0, 8'h00, 16'h0000, 16'h0000, 1, 0, 16'h0000, 0, 1, 0, 8'h07, 16'h0000, 1});
    vecs.push_back(vec_t'{1, 0, 8'h00, 1, 0, 8'h00, 16'h0000, 16'h3333, 0, 0, 16'h0000, 0, 0, 0, 8'h00, 16'h0000, 1});
    vecs.push_back(vec_t'{1, 0, 8'h00, 0, 0, 8'h00, 16'h0000, 16'h0000, 0, 0, 16'h0000, 0, 0, 0, 8'h00, 16'h0000, 0});

    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i < vecs.size(); i++) begin
      rst       = vecs[i].rst;
      f_req     = vecs[i].f_req;
      f_addr    = vecs[i].f_addr;
      f_flush   = vecs[i].f_flush;
      w_req     = vecs[i].w_req;
      w_addr    = vecs[i].w_addr;
      w_data    = vecs[i].w_data;
      mem_rdata = vecs[i].rdata;
      @(negedge clk);
      chk("f_gnt",     i, 32'(f_gnt),     32'(vecs[i].e_fgnt));
      chk("f_valid",   i, 32'(f_valid),   32'(vecs[i].e_fvld));
      chk("f_data",    i, 32'(f_data),    32'(vecs[i].e_fdata));
      chk("w_gnt",     i, 32'(w_gnt),     32'(vecs[i].e_wgnt));
      chk("mem_en",    i, 32'(mem_en),    32'(vecs[i].e_en));
      chk("mem_we",    i, 32'(mem_we),    32'(vecs[i].e_we));
      chk("mem_addr",  i, 32'(mem_addr),  32'(vecs[i].e_addr));
      chk("mem_wdata", i, 32'(mem_wdata), 32'(vecs[i].e_wdata));
      chk("busy",      i, 32'(busy),      32'(vecs[i].e_busy));
      @(posedge clk);
      #1;
    end

    // Both requesters held high continuously from a clean reset.
    rst = 1'b0; f_req = 1'b0; w_req = 1'b0; f_flush = 1'b0; mem_rdata = '0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    f_req = 1'b1; f_addr = 8'h08;
    w_req = 1'b1; w_addr = 8'h40; w_data = 16'h0F0F;
    wr_cnt = 0;
    rd_cnt = 0;
    since = 0;
    for (int c = 0; c < 33; c++) begin
      @(negedge clk);
      if (w_gnt === 1'b1) begin
        wr_cnt++;
        since++;
      end
      if (f_gnt === 1'b1) begin
        rd_cnt++;
        chk("writes_before_fetch", c, 32'(since), 32'(SMAX));
        since = 0;
      end
      @(posedge clk);
      #1;
    end
`ifdef IMEM_STARVE_GUARD_EN
    chk("starve_writes",  0, 32'(wr_cnt), 32'd12);
    chk("starve_fetches", 0, 32'(rd_cnt), 32'd3);
`else
    chk("starve_writes",  0, 32'(wr_cnt), 32'd16);
    chk("starve_fetches", 0, 32'(rd_cnt), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
